// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: feeder FSM encoding and byte width.
package uart_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        FEED_IDLE     = 2'd0,
        FEED_PRESENT  = 2'd1,
        FEED_WAIT_ACK = 2'd2
    } feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derive from the occupancy count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = BYTE_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Illegal requests (push when full, pop when empty) are silently dropped.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    assign full  = (count_r == COUNT_FULL);
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART bit transmitter,
// with an optional watchdog on the end-of-stop-bit acknowledge.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_data_ready,
    input  logic                   tx_ack,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam bit WDOG_EN = (ACK_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = WDOG_EN ? 32'(ACK_TIMEOUT - 1) : 32'd0;

    feed_state_t           state_r;
    logic [31:0]           wait_cnt_r;
    logic [BYTE_WIDTH-1:0] head_s;
    logic [CW-1:0]         count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  expired_s;

    assign push_s    = in_valid && !full_s;
    assign pop_s     = (state_r == FEED_IDLE) && !empty_s;
    assign expired_s = WDOG_EN && (wait_cnt_r == TIMEOUT_LAST);

    assign in_ready   = !full_s;
    assign fifo_count = count_s;
    assign busy       = (state_r != FEED_IDLE) || !empty_s;

    uart_sync_fifo #(
        .WIDTH (BYTE_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_data),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Handshake FSM with registered transmitter outputs and ack watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FEED_IDLE;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            timeout_err   <= 1'b0;
            wait_cnt_r    <= 32'd0;
        end else begin
            timeout_err <= 1'b0;
            case (state_r)
                FEED_IDLE: begin
                    if (!empty_s) begin
                        tx_data       <= head_s;
                        tx_data_valid <= 1'b1;
                        state_r       <= FEED_PRESENT;
                    end
                end
                FEED_PRESENT: begin
                    if (tx_data_ready) begin
                        tx_data_valid <= 1'b0;
                        wait_cnt_r    <= 32'd0;
                        state_r       <= FEED_WAIT_ACK;
                    end
                end
                FEED_WAIT_ACK: begin
                    // A timed-out byte counts as sent; it is never retried.
                    if (tx_ack) begin
                        state_r <= FEED_IDLE;
                    end else if (expired_s) begin
                        timeout_err <= 1'b1;
                        state_r     <= FEED_IDLE;
                    end else if (wait_cnt_r != 32'hFFFF_FFFF) begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                default: begin
                    tx_data_valid <= 1'b0;
                    state_r       <= FEED_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder: vector table plus multi-cycle sequences.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       tx_ack;
    logic [4:0] fifo_count;
    logic       busy;
    logic       timeout_err;

    logic [7:0] z_in_data;
    logic       z_in_valid;
    logic       z_in_ready;
    logic [7:0] z_tx_data;
    logic       z_tx_data_valid;
    logic       z_tx_data_ready;
    logic       z_tx_ack;
    logic [2:0] z_fifo_count;
    logic       z_busy;
    logic       z_timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16), .ACK_TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .tx_ack(tx_ack), .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err)
    );

    uart_tx_feeder #(.DEPTH(4), .ACK_TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(z_in_data), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .tx_data(z_tx_data), .tx_data_valid(z_tx_data_valid), .tx_data_ready(z_tx_data_ready),
        .tx_ack(z_tx_ack), .fifo_count(z_fifo_count), .busy(z_busy), .timeout_err(z_timeout_err)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       rdy;
        logic       ack;
        logic       ev;
        logic [7:0] ed;
        logic [4:0] ec;
        logic       eir;
        logic       eb;
    } vec_t;

    vec_t tbl [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: wait for a presented byte, accept it, then ack.
    task automatic tx_byte(input logic [7:0] exp);
        int n = 0;
        while (!tx_data_valid && n < 8) begin
            tick();
            n++;
        end
        chk("tx_valid_wait", {31'd0, tx_data_valid}, 32'd1);
        chk("tx_data_order", {24'd0, tx_data}, {24'd0, exp});
        tx_data_ready = 1'b1;
        tick();
        tx_data_ready = 1'b0;
        chk("tx_valid_drop", {31'd0, tx_data_valid}, 32'd0);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int terr_seen;
        int terr_at;

        rst = 1'b1;
        in_data = 8'h00; in_valid = 1'b0; tx_data_ready = 1'b0; tx_ack = 1'b0;
        z_in_data = 8'h00; z_in_valid = 1'b0; z_tx_data_ready = 1'b0; z_tx_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready",   {31'd0, in_ready}, 32'd1);
        chk("rst_tx_data",    {24'd0, tx_data}, 32'd0);
        chk("rst_tx_valid",   {31'd0, tx_data_valid}, 32'd0);
        chk("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        chk("rst_timeout",    {31'd0, timeout_err}, 32'd0);

        // single byte, stray handshakes, two-byte stream
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 5'd0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].id;
            tx_data_ready = tbl[i].rdy; tx_ack = tbl[i].ack;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, tx_data_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_data", i),  {24'd0, tx_data}, {24'd0, tbl[i].ed});
            chk($sformatf("vec%0d_count", i), {27'd0, fifo_count}, {27'd0, tbl[i].ec});
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].eir});
            chk($sformatf("vec%0d_busy", i),  {31'd0, busy}, {31'd0, tbl[i].eb});
            chk($sformatf("vec%0d_timeout", i), {31'd0, timeout_err}, 32'd0);
        end
        in_valid = 1'b0; tx_data_ready = 1'b0; tx_ack = 1'b0;

        // burst of 16 with the transmitter stalled, then overfill
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 8'(k);
            tick();
            chk("burst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        chk("burst_count15", {27'd0, fifo_count}, 32'd15);
        chk("burst_head", {24'd0, tx_data}, 32'h00);
        in_data = 8'h10;
        tick();
        chk("burst_count16", {27'd0, fifo_count}, 32'd16);
        chk("burst_full_ready", {31'd0, in_ready}, 32'd0);
        in_data = 8'h11;
        tick();
        chk("burst_reject_count", {27'd0, fifo_count}, 32'd16);
        tx_data_ready = 1'b1;
        tick();
        tx_data_ready = 1'b0;
        chk("burst_accept_drop", {31'd0, tx_data_valid}, 32'd0);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("burst_ack_count", {27'd0, fifo_count}, 32'd16);
        tick();
        chk("full_pop_count", {27'd0, fifo_count}, 32'd15);
        chk("full_pop_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tx_byte(8'(k));
        end
        chk("drain_count", {27'd0, fifo_count}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);

        // watchdog expiry
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_data = 8'h6B;
        tick();
        in_valid = 1'b0;
        chk("wd_first", {24'd0, tx_data}, 32'h5A);
        tx_data_ready = 1'b1;
        tick();
        tx_data_ready = 1'b0;
        terr_seen = 0;
        terr_at = -1;
        for (int n = 1; n <= 101; n++) begin
            tick();
            if (timeout_err) begin
                terr_seen++;
                if (terr_at < 0) terr_at = n;
            end
        end
        chk("wd_pulse_cycle", terr_at, 32'd100);
        chk("wd_pulse_count", terr_seen, 32'd1);
        chk("wd_next_valid", {31'd0, tx_data_valid}, 32'd1);
        chk("wd_next_data", {24'd0, tx_data}, 32'h6B);
        tx_byte(8'h6B);
        chk("wd_done_busy", {31'd0, busy}, 32'd0);

        // reset while presenting with five bytes queued
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = 8'h40 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count5", {27'd0, fifo_count}, 32'd5);
        chk("mid_present", {31'd0, tx_data_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, tx_data_valid}, 32'd0);
        chk("mid_rst_count", {27'd0, fifo_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        tx_ack = 1'b1;
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        tx_ack = 1'b0; in_valid = 1'b0;
        chk("post_rst_count", {27'd0, fifo_count}, 32'd1);
        tick();
        chk("post_rst_valid", {31'd0, tx_data_valid}, 32'd1);
        tx_byte(8'h3C);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // watchdog disabled: waits indefinitely for the ack
        z_in_valid = 1'b1; z_in_data = 8'h77;
        tick();
        z_in_valid = 1'b0;
        tick();
        chk("nowd_data", {24'd0, z_tx_data}, 32'h77);
        z_tx_data_ready = 1'b1;
        tick();
        z_tx_data_ready = 1'b0;
        terr_seen = 0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (z_timeout_err) terr_seen++;
        end
        chk("nowd_no_timeout", terr_seen, 32'd0);
        chk("nowd_still_busy", {31'd0, z_busy}, 32'd1);
        chk("nowd_valid_low", {31'd0, z_tx_data_valid}, 32'd0);
        z_tx_ack = 1'b1;
        tick();
        z_tx_ack = 1'b0;
        chk("nowd_ack_busy", {31'd0, z_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
